// File: rtl/ifu_imem_bridge.sv
// ifu_imem_bridge: memory-side responder for the fetch stage.
//   Watches pc, returns instr with a one-cycle instr_valid pulse. Reads 64-bit
//   doublewords over a req/gnt/rvalid port and keeps one doubleword buffered so
//   the other half of that doubleword is served without a memory access.
//   Misaligned fetches and memory timeouts return ERR_INSTR and set the sticky
//   fetch_err flag.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   pc                 fetch address, stable until instr_valid
//   instr, instr_valid fetched instruction and its one-cycle strobe
//   inv                buffer invalidate (fence.i / store to text)
//   mem_req, mem_addr  read request (held until mem_gnt), doubleword address
//   mem_gnt            request accepted this cycle
//   mem_rdata, mem_rvalid  read data return
//   fetch_err          sticky error flag, cleared only by reset
module ifu_imem_bridge #(
   parameter int unsigned TIMEOUT   = 256,
   parameter logic [31:0] ERR_INSTR = 32'h00100073
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        inv,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [63:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        fetch_err
);

   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [31:0]     instr_q, instr_d;
   logic            fetch_err_q, fetch_err_d;
   logic            buf_valid_q, buf_valid_d;
   logic [60:0]     buf_tag_q, buf_tag_d;
   logic [63:0]     buf_data_q, buf_data_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // pc[2] picks the upper or lower instruction of a doubleword.
   function automatic logic [31:0] sel_word(input logic [63:0] dw, input logic hi);
      return hi ? dw[63:32] : dw[31:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      fetch_err_d = fetch_err_q;
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      cnt_d       = cnt_q;
      mem_req     = 1'b0;
      mem_addr    = '0;

      if (inv) begin
         buf_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (pc[1:0] != 2'b00) begin
               instr_d     = ERR_INSTR;
               fetch_err_d = 1'b1;
               state_d     = StResp;
            end else if (buf_valid_q && (pc[63:3] == buf_tag_q) && !inv) begin
               instr_d = sel_word(buf_data_q, pc[2]);
               state_d = StResp;
            end else begin
               state_d = StReq;
            end
         end
         StReq: begin
            mem_req  = 1'b1;
            mem_addr = {pc[63:3], 3'b000};
            if (mem_gnt) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            // Data arriving on the last allowed cycle beats the timeout.
            if (mem_rvalid) begin
               buf_data_d  = mem_rdata;
               buf_tag_d   = pc[63:3];
               buf_valid_d = !inv;
               instr_d     = sel_word(mem_rdata, pc[2]);
               state_d     = StResp;
            end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
               instr_d     = ERR_INSTR;
               fetch_err_d = 1'b1;
               state_d     = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= StIdle;
         instr_q     <= '0;
         fetch_err_q <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         fetch_err_q <= fetch_err_d;
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
         cnt_q       <= cnt_d;
      end
   end

   assign instr       = instr_q;
   assign instr_valid = (state_q == StResp);
   assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_ifu_imem_bridge.sv
// Self-checking bench for ifu_imem_bridge (instantiated with TIMEOUT=8).
// Table of fetch records driven through a handshake task, plus a hand-written
// reset-during-WAIT sequence.
module tb_ifu_imem_bridge;

   logic        clk;
   logic        rstn;
   logic [63:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        inv;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_gnt;
   logic [63:0] mem_rdata;
   logic        mem_rvalid;
   logic        fetch_err;

   int n_checks = 0;
   int n_errors = 0;

   ifu_imem_bridge #(
      .TIMEOUT  (8),
      .ERR_INSTR(32'h00100073)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .pc         (pc),
      .instr      (instr),
      .instr_valid(instr_valid),
      .inv        (inv),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .fetch_err  (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic        inv;       // inv during the IDLE sample cycle
      logic        inv_rv;    // inv together with mem_rvalid
      int          gd;        // stalled gnt cycles
      int          rd;        // stalled rvalid cycles (large = never)
      logic [63:0] rdata;
      logic [31:0] exp_instr;
      int          exp_lat;
      int          exp_reqs;
      logic        exp_err;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Entered on a negedge in an IDLE cycle; returns on the negedge of the next IDLE cycle.
   task automatic run_fetch(input vec_t v, input int idx);
      logic        granted;
      logic        got;
      int          wcnt;
      int          reqs;
      int          lat;
      logic [31:0] got_instr;
      logic        got_err;
      granted   = 1'b0;
      got       = 1'b0;
      wcnt      = 0;
      reqs      = 0;
      lat       = 0;
      got_instr = '0;
      got_err   = 1'b0;
      pc        = v.pc;
      inv       = v.inv;
      mem_gnt   = 1'b0;
      mem_rvalid = 1'b0;
      for (int c = 1; c <= 64 && !got; c++) begin
         @(negedge clk);
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         inv        = 1'b0;
         if (instr_valid) begin
            got       = 1'b1;
            lat       = c;
            got_instr = instr;
            got_err   = fetch_err;
         end else begin
            if (granted) begin
               wcnt++;
               if (wcnt > v.rd) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = v.rdata;
                  inv        = v.inv_rv;
               end
            end
            if (mem_req) begin
               reqs++;
               check($sformatf("v%0d_addr", idx), mem_addr, {v.pc[63:3], 3'b000});
               if (reqs > v.gd) begin
                  mem_gnt = 1'b1;
                  granted = 1'b1;
               end
            end
         end
      end
      check($sformatf("v%0d_done", idx), 64'(got), 64'd1);
      if (got) begin
         check($sformatf("v%0d_instr", idx), 64'(got_instr), 64'(v.exp_instr));
         check($sformatf("v%0d_lat", idx), 64'(lat), 64'(v.exp_lat));
         check($sformatf("v%0d_reqs", idx), 64'(reqs), 64'(v.exp_reqs));
         check($sformatf("v%0d_err", idx), 64'(got_err), 64'(v.exp_err));
      end
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      check($sformatf("v%0d_pulse", idx), 64'(instr_valid), 64'd0);
   endtask

   initial begin
      //          pc             inv   inv_rv gd rd   rdata                  instr         lat reqs err
      vecs[0]  = '{64'h80000000, 1'b0, 1'b0, 0, 0,   64'h00000513_00100093, 32'h00100093, 3,  1, 1'b0};
      vecs[1]  = '{64'h80000004, 1'b0, 1'b0, 0, 0,   64'h0,                 32'h00000513, 1,  0, 1'b0};
      vecs[2]  = '{64'h80000008, 1'b0, 1'b0, 4, 5,   64'h11111111_22222222, 32'h22222222, 12, 5, 1'b0};
      vecs[3]  = '{64'h8000000C, 1'b0, 1'b0, 0, 0,   64'h0,                 32'h11111111, 1,  0, 1'b0};
      vecs[4]  = '{64'h80000000, 1'b0, 1'b0, 1, 0,   64'hDEADBEEF_CAFEF00D, 32'hCAFEF00D, 4,  2, 1'b0};
      vecs[5]  = '{64'h80000004, 1'b1, 1'b0, 0, 0,   64'h12345678_9ABCDEF0, 32'h12345678, 3,  1, 1'b0};
      vecs[6]  = '{64'h80000000, 1'b0, 1'b0, 0, 0,   64'h0,                 32'h9ABCDEF0, 1,  0, 1'b0};
      vecs[7]  = '{64'h80000002, 1'b0, 1'b0, 0, 0,   64'h0,                 32'h00100073, 1,  0, 1'b1};
      vecs[8]  = '{64'h80000004, 1'b0, 1'b0, 0, 0,   64'h0,                 32'h12345678, 1,  0, 1'b1};
      vecs[9]  = '{64'h80000010, 1'b0, 1'b0, 0, 100, 64'h0,                 32'h00100073, 10, 1, 1'b1};
      vecs[10] = '{64'h80000000, 1'b0, 1'b0, 0, 0,   64'h0,                 32'h9ABCDEF0, 1,  0, 1'b1};
      vecs[11] = '{64'h80000010, 1'b0, 1'b0, 0, 7,   64'h00000001_00000002, 32'h00000002, 10, 1, 1'b1};
      vecs[12] = '{64'h80000020, 1'b0, 1'b1, 0, 0,   64'h55555555_66666666, 32'h66666666, 3,  1, 1'b1};
      vecs[13] = '{64'h80000024, 1'b0, 1'b0, 0, 0,   64'h77777777_88888888, 32'h77777777, 3,  1, 1'b1};

      rstn       = 1'b0;
      pc         = 64'h0;
      inv        = 1'b0;
      mem_gnt    = 1'b0;
      mem_rdata  = 64'h0;
      mem_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_instr", 64'(instr), 64'd0);
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_req", 64'(mem_req), 64'd0);
      check("rst_addr", mem_addr, 64'd0);
      check("rst_err", 64'(fetch_err), 64'd0);
      rstn = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_fetch(vecs[i], i);
      end

      // Reset while in WAIT, then a stray rvalid; buffer must come back empty.
      pc = 64'h80000030;
      @(negedge clk);
      check("mr_req", 64'(mem_req), 64'd1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      rstn    = 1'b0;
      @(negedge clk);
      check("mr_req_drop", 64'(mem_req), 64'd0);
      check("mr_valid", 64'(instr_valid), 64'd0);
      check("mr_err_clr", 64'(fetch_err), 64'd0);
      check("mr_instr", 64'(instr), 64'd0);
      rstn       = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hFFFFFFFF_EEEEEEEE;
      pc         = 64'h80000024;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("mr_stray_valid", 64'(instr_valid), 64'd0);
      check("mr_buf_miss", 64'(mem_req), 64'd1);
      check("mr_addr", mem_addr, 64'h80000020);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hAAAAAAAA_BBBBBBBB;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("mr_resp_valid", 64'(instr_valid), 64'd1);
      check("mr_resp_instr", 64'(instr), 64'hAAAAAAAA);
      check("mr_resp_err", 64'(fetch_err), 64'd0);
      @(negedge clk);
      check("mr_pulse", 64'(instr_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ifu_imem_bridge.md
Name: ifu_imem_bridge

Overview:
- Memory-side responder for the pipeline fetch stage. Watches the fetch stage's `pc` and returns `instr` with a single-cycle `instr_valid` pulse, which is what the fetch stage needs to advance `pc` and load its pipeline register.
- Reads 64-bit doublewords over a req/gnt/rvalid memory port. Keeps a one-entry doubleword buffer so the second half of a doubleword needs no memory access.
- Flags misaligned fetches and memory timeouts.

Parameters:
- TIMEOUT, 256, max cycles waited in WAIT for mem_rvalid; 0 disables the timeout.
- ERR_INSTR, 32'h00100073, instruction returned on error (ebreak, halts simulation).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- pc  input  64  fetch address from fetch stage; stable until instr_valid
- instr  output  32  fetched instruction, valid with instr_valid
- instr_valid  output  1  one-cycle pulse, one per fetch
- inv  input  1  buffer invalidate (fence.i / store to text)
- mem_req  output  1  read request, held until mem_gnt
- mem_addr  output  64  {pc[63:3],3'b0}
- mem_gnt  input  1  request accepted this cycle
- mem_rdata  input  64  read doubleword
- mem_rvalid  input  1  mem_rdata valid
- fetch_err  output  1  sticky error flag (misalign or timeout)

Behaviour:
- Reset values:
  - state=IDLE
  - instr=0, instr_valid=0
  - mem_req=0, mem_addr=0
  - fetch_err=0
  - buf_valid=0, buf_tag=0, buf_data=0, wait counter=0
- States: IDLE, REQ, WAIT, RESP. instr and instr_valid are registered and driven from RESP only.
- IDLE: evaluate pc every cycle. Priority order:
  - pc[1:0]!=0: instr<=ERR_INSTR, fetch_err<=1, go RESP.
  - buf_valid && pc[63:3]==buf_tag && !inv: instr<=pc[2]?buf_data[63:32]:buf_data[31:0], go RESP.
  - otherwise: go REQ.
- REQ:
  - mem_req=1, mem_addr={pc[63:3],3'b0}.
  - On mem_gnt: go WAIT, counter<=0.
  - Without mem_gnt: hold; no timeout applies in REQ.
- WAIT: mem_req=0, counter increments each cycle.
  - On mem_rvalid: buf_data<=mem_rdata, buf_tag<=pc[63:3], buf_valid<=!inv, instr<=word selected by pc[2], go RESP.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with no mem_rvalid: instr<=ERR_INSTR, fetch_err<=1, go RESP.
  - mem_rvalid and timeout in the same cycle: the data wins.
- RESP: instr_valid=1 for exactly one cycle, then go IDLE. pc may change on the following cycle.
- Latency, counted from the cycle pc is first sampled in IDLE:
  - Hit or misalign: instr_valid 1 cycle later.
  - Miss: instr_valid 3 cycles later, with gnt in the REQ cycle and rvalid in the first WAIT cycle. Each stalled gnt or rvalid cycle adds 1.
- Back-to-back sequential fetches: 0x80000000 miss, 0x80000004 hit, 0x80000008 miss.
- inv:
  - Clears buf_valid in any state.
  - In IDLE, inv forces a miss that same cycle.
  - inv coinciding with mem_rvalid: the current fetch still returns the data, but the buffer stays invalid.
- Stray mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.
- Reset mid-transaction: state returns to IDLE and mem_req drops next edge. A late mem_rvalid after reset is ignored, because the block is not in WAIT.
- fetch_err is cleared only by reset.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit; it never wraps, since a timeout leaves WAIT.

Test Plan:
- Reset then pc=0x80000000, mem_gnt same cycle, rvalid next cycle with rdata=0x00000513_00100093 -> instr=0x00100093, instr_valid pulse at cycle 3, mem_addr=0x80000000.
- pc then 0x80000004 -> hit, no mem_req, instr=0x00000513 one cycle after IDLE sample.
- mem_gnt delayed 4 cycles, rvalid delayed 5 -> mem_req held 5 cycles, single instr_valid pulse, exactly one request issued.
- pc=0x80000002 -> instr=0x00100073, fetch_err=1, no mem_req; fetch_err stays 1 on subsequent good fetches until rstn=0.
- TIMEOUT=8, no rvalid -> instr_valid 8 cycles after entering WAIT, instr=0x00100073, fetch_err=1. Then inv pulse together with a later rvalid -> data returned, the next fetch to the same doubleword is a miss.
- rstn low for one cycle while in WAIT, then rvalid -> mem_req=0, no instr_valid, state IDLE, buf_valid=0.
